// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer driving one external full adder, LSB first.
// Operands are latched on START; one bit is processed per clock in SHIFT.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_C,
    input  logic             FA_SUM,
    input  logic             FA_CARRY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY_OUT,
    output logic             OVERFLOW,
    output logic [1:0]       DEBUG_STATE
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             carry_q;
    logic [CW-1:0]    count;
    logic             last_bit;

    assign last_bit = (state == SHIFT) && (count == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (START) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder inputs come straight from registers and are forced low outside SHIFT.
    assign FA_A        = (state == SHIFT) & a_sh[0];
    assign FA_B        = (state == SHIFT) & b_sh[0];
    assign FA_C        = (state == SHIFT) & carry_q;
    assign BUSY        = (state != IDLE);
    assign DONE        = (state == FIN);
    assign DEBUG_STATE = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry_q   <= 1'b0;
            count     <= '0;
            RESULT    <= '0;
            CARRY_OUT <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        a_sh    <= OPERAND1;
                        b_sh    <= SUB ? ~OPERAND2 : OPERAND2;
                        carry_q <= SUB;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    r_sh    <= {FA_SUM, r_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= FA_CARRY;
                    count   <= count + 1'b1;
                    // carry_q here is the carry into the MSB position.
                    if (last_bit) begin
                        RESULT    <= {FA_SUM, r_sh[WIDTH-1:1]};
                        CARRY_OUT <= FA_CARRY;
                        OVERFLOW  <= carry_q ^ FA_CARRY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
